lpc_wb_bridge: RTL and testbench

Bridge from the LPC2294 external memory controller (async SRAM-style bus, 32-bit data, 24-bit address, one chip select) to the on-chip Wishbone bus that feeds the system register block and other slaves. It synchronises the ARM strobes into sys_clk_i and runs exactly one Wishbone classic cycle per ARM access. It returns read data on the ARM bus and raises a sticky error on bus error or timeout. It sits directly upstream of the system control/hex-display register block.

---
 rtl/lpc_wb_bridge_pkg.sv | 20 ++
 rtl/lpc_wb_bridge_sync2_n.sv | 23 ++
 rtl/lpc_wb_bridge.sv | 133 +++++++++++++
 tb/tb_lpc_wb_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_wb_bridge_pkg.sv
// Shared types and constants for the LPC2294 EMC to Wishbone bridge.
package lpc_wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB_RD = 2'd1,
    WB_WR = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] BAD_DATA_DEF = 32'hdead_beef;
  localparam int          LPC_ADDR_W   = 24;

  // The 24-bit ARM address lands in the low bits; the base fills in above bit 23.
  function automatic logic [31:0] wb_addr(input logic [31:0] base,
                                          input logic [LPC_ADDR_W-1:0] addr);
    return base | {8'h00, addr};
  endfunction

endpackage

// File: rtl/lpc_wb_bridge_sync2_n.sv
// Two-flop synchroniser for active-low strobes; resets to the inactive level.
module lpc_wb_bridge_sync2_n #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lpc_wb_bridge.sv
// LPC2294 EMC (async SRAM-style) to Wishbone classic bridge: one Wishbone
// cycle per ARM strobe, read data returned to the pads, sticky error flag.
module lpc_wb_bridge
  import lpc_wb_bridge_pkg::*;
#(
  parameter logic [31:0] WB_BASE  = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] BAD_DATA = BAD_DATA_DEF
) (
  input  logic        sys_clk_i,
  input  logic        async_rst_n_i,
  input  logic        lpc_cs_n_i,
  input  logic        lpc_oe_n_i,
  input  logic        lpc_we_n_i,
  input  logic [3:0]  lpc_bls_n_i,
  input  logic [23:0] lpc_addr_i,
  input  logic [31:0] lpc_data_i,
  output logic [31:0] lpc_data_o,
  output logic        lpc_data_oe_o,
  output logic [31:0] sys_addr_o,
  output logic [31:0] sys_data_o,
  input  logic [31:0] sys_data_i,
  output logic [3:0]  sys_sel_o,
  output logic        sys_we_o,
  output logic        sys_cyc_o,
  output logic        sys_stb_o,
  input  logic        sys_ack_i,
  input  logic        sys_err_i,
  output logic        bridge_err_o,
  input  logic        err_clr_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                 state, state_nx;
  logic                   cs_s, oe_s, we_s;
  logic                   rd_act, wr_act;
  logic                   in_wb, tmo, done_ok, done_bad, launch;
  logic [LPC_ADDR_W-1:0]  addr_r;
  logic [31:0]            wdata_r;
  logic [3:0]             sel_r;
  logic                   is_rd;
  logic [CNT_W-1:0]       cnt;

  lpc_wb_bridge_sync2_n #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(sys_clk_i), .rst_n(async_rst_n_i), .d(lpc_cs_n_i), .q(cs_s)
  );
  lpc_wb_bridge_sync2_n #(.RST_VAL(1'b1)) u_sync_oe (
    .clk(sys_clk_i), .rst_n(async_rst_n_i), .d(lpc_oe_n_i), .q(oe_s)
  );
  lpc_wb_bridge_sync2_n #(.RST_VAL(1'b1)) u_sync_we (
    .clk(sys_clk_i), .rst_n(async_rst_n_i), .d(lpc_we_n_i), .q(we_s)
  );

  assign rd_act   = ~cs_s & ~oe_s;
  assign wr_act   = ~cs_s & ~we_s;
  assign in_wb    = (state == WB_RD) || (state == WB_WR);
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));
  // ack wins over a simultaneous err; timeout only counts when nothing answered
  assign done_ok  = in_wb & sys_ack_i;
  assign done_bad = in_wb & ~sys_ack_i & (sys_err_i | tmo);
  assign launch   = (state == IDLE) & (rd_act | wr_act);

  assign sys_addr_o = wb_addr(WB_BASE, addr_r);
  assign sys_data_o = wdata_r;
  assign sys_sel_o  = sel_r;

  always_ff @(posedge sys_clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    sys_cyc_o     = 1'b0;
    sys_stb_o     = 1'b0;
    sys_we_o      = 1'b0;
    lpc_data_oe_o = 1'b0;
    case (state)
      IDLE: begin
        if (wr_act)      state_nx = WB_WR;
        else if (rd_act) state_nx = WB_RD;
      end
      WB_RD, WB_WR: begin
        sys_cyc_o = 1'b1;
        sys_stb_o = 1'b1;
        sys_we_o  = (state == WB_WR);
        if (done_ok || done_bad) state_nx = HOLD;
      end
      HOLD: begin
        lpc_data_oe_o = is_rd & rd_act;
        // wait for the ARM strobe to lift so one strobe never retriggers
        if (!rd_act && !wr_act) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Launch capture, timeout count, read-data return and sticky error
  always_ff @(posedge sys_clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      addr_r       <= '0;
      wdata_r      <= '0;
      sel_r        <= '0;
      is_rd        <= 1'b0;
      cnt          <= '0;
      lpc_data_o   <= '0;
      bridge_err_o <= 1'b0;
    end else begin
      if (launch) begin
        addr_r <= lpc_addr_i;
        cnt    <= '0;
        if (wr_act) begin
          wdata_r <= lpc_data_i;
          sel_r   <= ~lpc_bls_n_i;
          is_rd   <= 1'b0;
        end else begin
          sel_r   <= 4'hf;
          is_rd   <= 1'b1;
        end
      end else if (in_wb) begin
        cnt <= cnt + 1'b1;
      end

      if (is_rd && done_ok)       lpc_data_o <= sys_data_i;
      else if (is_rd && done_bad) lpc_data_o <= BAD_DATA;

      if (done_bad)       bridge_err_o <= 1'b1;
      else if (err_clr_i) bridge_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lpc_wb_bridge.sv
// Scoreboard bench for lpc_wb_bridge: randomized ARM accesses against a Wishbone slave model.
`timescale 1ns/1ps
module tb_lpc_wb_bridge;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] BAD     = 32'hdead_beef;
  localparam int          M_OK = 0, M_ERR = 1, M_NOACK = 2, M_ACKERR = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lpc_cs_n, lpc_oe_n, lpc_we_n;
  logic [3:0]  lpc_bls_n;
  logic [23:0] lpc_addr;
  logic [31:0] lpc_wdata, lpc_rdata;
  logic        pad_oe;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_sel;
  logic        sys_we, sys_cyc, sys_stb, sys_ack, sys_err;
  logic        bridge_err, err_clr;

  always #5 clk = ~clk;

  lpc_wb_bridge dut (
    .sys_clk_i(clk), .async_rst_n_i(rst_n),
    .lpc_cs_n_i(lpc_cs_n), .lpc_oe_n_i(lpc_oe_n), .lpc_we_n_i(lpc_we_n),
    .lpc_bls_n_i(lpc_bls_n), .lpc_addr_i(lpc_addr), .lpc_data_i(lpc_wdata),
    .lpc_data_o(lpc_rdata), .lpc_data_oe_o(pad_oe),
    .sys_addr_o(sys_addr), .sys_data_o(sys_wdata), .sys_data_i(sys_rdata),
    .sys_sel_o(sys_sel), .sys_we_o(sys_we), .sys_cyc_o(sys_cyc), .sys_stb_o(sys_stb),
    .sys_ack_i(sys_ack), .sys_err_i(sys_err),
    .bridge_err_o(bridge_err), .err_clr_i(err_clr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
    int          len;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];
  int          checks = 0, errors = 0;
  int          slv_mode = 0, slv_wait = 0, slv_cnt = 0;
  logic        err_exp = 1'b0;

  wb_exp_t cur;
  logic    cur_valid = 1'b0, stb_prev = 1'b0, oe_prev = 1'b0;
  int      stb_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wishbone slave: answers after slv_wait cycles according to slv_mode
  initial begin
    sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = '0;
    forever begin
      @(posedge clk); #1;
      sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = $urandom;
      if (sys_cyc && sys_stb) begin
        if (slv_cnt == slv_wait) begin
          if (slv_mode == M_OK || slv_mode == M_ACKERR) begin
            sys_ack = 1'b1;
            if (sys_we) begin
              for (int b = 0; b < 4; b++)
                if (sys_sel[b]) slv_mem[sys_addr[9:2]][8*b +: 8] = sys_wdata[8*b +: 8];
            end else begin
              sys_rdata = slv_mem[sys_addr[9:2]];
            end
          end
          if (slv_mode == M_ERR || slv_mode == M_ACKERR) sys_err = 1'b1;
        end
        slv_cnt++;
      end else begin
        slv_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations on each strobe launch and each pad-enable rise
  initial begin
    forever begin
      @(negedge clk);
      if (sys_stb && !stb_prev) begin
        stb_len = 0;
        if (wb_q.size() == 0) begin
          checks++; errors++; cur_valid = 1'b0;
          $display("FAIL extra_stb actual=1 required=0 addr=%h", sys_addr);
        end else begin
          cur = wb_q.pop_front(); cur_valid = 1'b1;
          chk("wb_addr", sys_addr, cur.addr);
          chk("wb_sel", 32'(sys_sel), 32'(cur.sel));
          chk("wb_we", 32'(sys_we), 32'(cur.we));
          chk("wb_cyc", 32'(sys_cyc), 32'd1);
          if (cur.we) chk("wb_wdata", sys_wdata, cur.data);
        end
      end
      if (sys_stb) stb_len++;
      if (!sys_stb && stb_prev && cur_valid && cur.len >= 0)
        chk("stb_len", 32'(stb_len), 32'(cur.len));
      if (pad_oe && !oe_prev) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_pad_oe actual=1 required=0");
        end else begin
          chk("rd_data", lpc_rdata, rd_q.pop_front());
        end
      end
      stb_prev = sys_stb;
      oe_prev  = pad_oe;
    end
  end

  task automatic arm_access(input logic we, input logic [23:0] a, input logic [31:0] d,
                            input logic [3:0] bls, input int mode, input int wt,
                            input logic early);
    wb_exp_t     e;
    logic [31:0] mask;
    logic        bad;
    int          idx, n;
    slv_mode = mode;
    slv_wait = wt;
    idx  = int'(a[9:2]);
    bad  = (mode == M_ERR) || (mode == M_NOACK);
    e.addr = {8'h00, a};
    e.data = d;
    e.sel  = we ? ~bls : 4'hf;
    e.we   = we;
    e.len  = (mode == M_NOACK) ? TIMEOUT : wt + 1;
    if (we) begin
      mask = {{8{e.sel[3]}}, {8{e.sel[2]}}, {8{e.sel[1]}}, {8{e.sel[0]}}};
      if (!bad) ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
    end else if (!early) begin
      rd_q.push_back(bad ? BAD : ref_mem[idx]);
    end
    if (bad) err_exp = 1'b1;
    wb_q.push_back(e);

    @(negedge clk);
    lpc_addr = a; lpc_wdata = d; lpc_bls_n = bls; lpc_cs_n = 1'b0;
    if (we) lpc_we_n = 1'b0; else lpc_oe_n = 1'b0;
    n = 0;
    while (!sys_stb && n < 20) begin @(negedge clk); n++; end
    chk("launch_lat", 32'(n), 32'd3);
    if (early) begin lpc_oe_n = 1'b1; lpc_cs_n = 1'b1; end
    n = 0;
    while (sys_stb && n < 40) begin @(negedge clk); n++; end
    chk("stb_dropped", 32'(sys_stb), 32'd0);
    if (!early) begin
      repeat (3) @(negedge clk);
      chk("pad_oe_hold", 32'(pad_oe), 32'(!we));
    end
    lpc_cs_n = 1'b1; lpc_oe_n = 1'b1; lpc_we_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("pad_oe_off", 32'(pad_oe), 32'd0);
    chk("err_flag", 32'(bridge_err), 32'(err_exp));
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(bridge_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_exp_t     e;
    int          n, r, md;
    logic [31:0] v;
    rst_n = 1'b0; err_clr = 1'b0;
    lpc_cs_n = 1'b1; lpc_oe_n = 1'b1; lpc_we_n = 1'b1;
    lpc_bls_n = 4'hf; lpc_addr = '0; lpc_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; ref_mem[i] = v; slv_mem[i] = v;
    end
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(sys_cyc), 32'd0);
    chk("rst_stb", 32'(sys_stb), 32'd0);
    chk("rst_we", 32'(sys_we), 32'd0);
    chk("rst_addr", sys_addr, 32'd0);
    chk("rst_wdata", sys_wdata, 32'd0);
    chk("rst_sel", 32'(sys_sel), 32'd0);
    chk("rst_rdata", lpc_rdata, 32'd0);
    chk("rst_pad_oe", 32'(pad_oe), 32'd0);
    chk("rst_err", 32'(bridge_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    arm_access(1'b1, 24'h000004, 32'h0000_1234, 4'b0000, M_OK, 0, 1'b0);
    ref_mem[0] = 32'h1; slv_mem[0] = 32'h1;
    arm_access(1'b0, 24'h000000, 32'h0, 4'h0, M_OK, 0, 1'b0);
    arm_access(1'b1, 24'h000008, 32'haabb_ccdd, 4'b1110, M_OK, 1, 1'b0);
    arm_access(1'b0, 24'h000008, 32'h0, 4'h0, M_OK, 2, 1'b0);
    arm_access(1'b0, 24'h000010, 32'h0, 4'h0, M_NOACK, 0, 1'b0);
    clear_err();
    arm_access(1'b1, 24'h00000c, 32'h5555_aaaa, 4'b0000, M_ERR, 1, 1'b0);
    clear_err();
    arm_access(1'b1, 24'h00000c, 32'h1111_2222, 4'b0000, M_ACKERR, 0, 1'b0);
    arm_access(1'b0, 24'h00000c, 32'h0, 4'h0, M_OK, 0, 1'b0);
    arm_access(1'b0, 24'h000014, 32'h0, 4'h0, M_OK, 6, 1'b1);

    // Reset while a write is stalled on the bus
    slv_mode = M_NOACK;
    e.addr = 32'h0000_0020; e.data = 32'hcafe_f00d; e.sel = 4'hf; e.we = 1'b1; e.len = -1;
    wb_q.push_back(e);
    @(negedge clk);
    lpc_addr = 24'h000020; lpc_wdata = 32'hcafe_f00d; lpc_bls_n = 4'h0;
    lpc_cs_n = 1'b0; lpc_we_n = 1'b0;
    n = 0;
    while (!sys_stb && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(sys_cyc), 32'd0);
    chk("mid_rst_stb", 32'(sys_stb), 32'd0);
    chk("mid_rst_err", 32'(bridge_err), 32'd0);
    err_exp = 1'b0;
    lpc_cs_n = 1'b1; lpc_we_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_stb", 32'(sys_stb), 32'd0);
    arm_access(1'b0, 24'h000004, 32'h0, 4'h0, M_OK, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      md = (r == 0) ? M_ERR : (r == 1) ? M_ACKERR : (r == 2) ? M_NOACK : M_OK;
      arm_access(1'($urandom_range(0, 1)), 24'($urandom), $urandom, 4'($urandom),
                 md, $urandom_range(0, 3), 1'b0);
      if (err_exp && $urandom_range(0, 1) == 1) clear_err();
    end

    repeat (4) @(negedge clk);
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
